axi4_rx_wr_master: RTL
======================

Name: axi4_rx_wr_master

Overview:
- Downstream of RX transaction-layer decode: converts each decoded memory-write request plus its payload stream into one AXI4 INCR write burst.
- Drives the AW and W channels and consumes the B channel, using the team AXI4 interfaces.
- Tracks outstanding write responses and reports error status.
- Sits between the RX TLP decoder and the AXI fabric toward memory.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 256, payload/W data width; STRB_WIDTH = DATA_WIDTH/8.
- MAX_OUTSTANDING, 8, maximum AW issued without a B response; range 1..255.

Ports:
aclk  input  1  clock; all logic on posedge
areset_n  input  1  reset, asynchronous assert, active-low
req_valid  input  1  write request valid
req_ready  output  1  request accepted when high with req_valid
req_addr  input  ADDR_WIDTH  burst start address, DATA_WIDTH/8-aligned
req_len  input  8  beats minus 1 (0..255)
req_id  input  ID_WIDTH  AXI ID for the burst
din_valid  input  1  payload beat valid
din_ready  output  1  payload beat accepted
din_data  input  DATA_WIDTH  payload data
din_strb  input  STRB_WIDTH  byte enables
din_last  input  1  final payload beat of the request
aw_if  modport  AXI4_A_IF.master  write address channel
w_if  modport  AXI4_W_IF.master  write data channel
b_if  modport  AXI4_B_IF.master  write response channel
outstanding  output  8  AW issued minus B received
err_cnt  output  16  count of B responses with bresp != OKAY, saturating
proto_err  output  1  sticky: din_last disagreed with the beat count
idle  output  1  state IDLE and outstanding == 0

Behaviour:
- Reset: state IDLE; req_ready=0, din_ready=0, avalid=0, wvalid=0, bready=0, outstanding=0, err_cnt=0, proto_err=0, idle=1.
- Reset assertion mid-burst aborts the burst immediately. Outstanding responses are forgotten.
- FSM states: IDLE, AW, W.
- IDLE:
  - req_ready = (outstanding < MAX_OUTSTANDING).
  - On req_valid & req_ready: latch addr/len/id, clear beat_cnt, go to AW.
  - avalid rises the next cycle (1-cycle latency).
- AW:
  - avalid=1. aaddr/aid/alen come from the latch.
  - Fixed fields: asize=log2(STRB_WIDTH) (5 at default), aburst=INCR, acache=0, aprot=0, aqos=0, aregion=0.
  - Fields are held stable until aready.
  - On avalid & aready: outstanding+1, go to W. The W phase never starts before the AW handshake completes.
- W:
  - Combinational pass-through: wvalid=din_valid, din_ready=wready, wdata=din_data, wstrb=din_strb.
  - wlast = (beat_cnt == len), generated internally; din_last does not drive it.
  - Each wvalid & wready increments beat_cnt.
  - On the handshake with wlast=1: go to IDLE. req_ready may assert the following cycle (no back-to-back in the same cycle).
  - If din_last != wlast on any accepted beat: proto_err <= 1 (sticky). The burst still completes to len+1 beats.
- B channel:
  - bready=1 whenever out of reset.
  - Each bvalid handshake decrements outstanding.
  - bresp != 2'b00 increments err_cnt, saturating at 16'hFFFF.
- Simultaneous AW handshake and B handshake in one cycle: outstanding unchanged.
- B handshake while outstanding==0 is a protocol violation: simulation assertion fires; counter holds at 0 (no underflow).
- Full condition: outstanding == MAX_OUTSTANDING blocks new requests only. An in-flight burst always completes.
- 4KB boundary: the requester guarantees addr + (len+1)*STRB_WIDTH does not cross 4KB. A simulation-only assertion checks this.
- Arithmetic: beat_cnt is 8 bits; its compare against len never wraps because len <= 255.

Decomposition:
- Shared package axi4_pkg:
  - constants AXI_BURST_INCR=2'b01, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - function axi_size(bytes) returning asize;
  - typedef wr_req_t {addr, len, id} for the latched request.
- Optional sub-module sat_updown_cnt (parameterized up/down counter with saturation), used for outstanding.
- Everything else lives inline in one module.

Test Plan:
- Single beat: req addr=0x1000, len=0, id=3; one din beat with last=1. Expect one AW with alen=0, asize=5, aburst=01; one W with wlast=1; B OKAY returns outstanding to 0 and idle=1.
- 16-beat burst, len=15: wready toggles 1/0 every cycle. Expect 16 W beats in order, wlast only on the 16th, data/strb stable while wready=0, no W before the AW handshake.
- Outstanding limit: MAX_OUTSTANDING=2, bvalid held 0, three requests. Expect req_ready=0 after the 2nd AW. A B response re-enables the 3rd, and outstanding peaks at 2.
- Simultaneous events: AW handshake and bvalid in the same cycle with outstanding=1. Expect outstanding stays 1.
- Errors: B with bresp=SLVERR then DECERR. Expect err_cnt=2 and outstanding decremented both times. Separately, din_last=1 on beat 2 of len=3. Expect proto_err=1 and 4 beats still sent.
- Reset mid-burst: assert areset_n=0 at beat 5 of 8. Expect avalid/wvalid/din_ready=0 asynchronously; after release, state IDLE, outstanding=0, and a fresh request completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, request record, FSM state type and size helper.
package axi4_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Widths of the latched request record; the write master defaults match them.
   localparam int AXI_ADDR_W = 64;
   localparam int AXI_ID_W   = 4;

   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [AXI_ID_W-1:0]   id;
   } wr_req_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AW,
      ST_W
   } wr_state_e;

   // Encodes a power-of-two beat size in bytes as the AXI AxSIZE field.
   function automatic logic [2:0] axi_size(input int bytes);
      logic [2:0] sz;
      sz = '0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) == bytes) sz = 3'(i);
      end
      return sz;
   endfunction

endpackage

// File: rtl/axi4_rx_wr_master_if.sv
// Team AXI4 write-path channel interfaces: address, write data, write response.
interface AXI4_A_IF #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 64
);
   logic                  avalid;
   logic                  aready;
   logic [ADDR_WIDTH-1:0] aaddr;
   logic [ID_WIDTH-1:0]   aid;
   logic [7:0]            alen;
   logic [2:0]            asize;
   logic [1:0]            aburst;
   logic [3:0]            acache;
   logic [2:0]            aprot;
   logic [3:0]            aqos;
   logic [3:0]            aregion;

   modport master (output avalid, aaddr, aid, alen, asize, aburst, acache, aprot, aqos, aregion,
                   input  aready);
   modport slave  (input  avalid, aaddr, aid, alen, asize, aburst, acache, aprot, aqos, aregion,
                   output aready);
endinterface

interface AXI4_W_IF #(
   parameter int DATA_WIDTH = 256
);
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;

   modport master (output wvalid, wdata, wstrb, wlast, input  wready);
   modport slave  (input  wvalid, wdata, wstrb, wlast, output wready);
endinterface

interface AXI4_B_IF #(
   parameter int ID_WIDTH = 4
);
   logic                bvalid;
   logic                bready;
   logic [ID_WIDTH-1:0] bid;
   logic [1:0]          bresp;

   modport master (input  bvalid, bid, bresp, output bready);
   modport slave  (output bvalid, bid, bresp, input  bready);
endinterface

// File: rtl/sat_updown_cnt.sv
// Up/down counter that holds at zero and at all-ones instead of wrapping.
module sat_updown_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // Simultaneous inc and dec cancel; each direction stops at its limit.
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/axi4_rx_wr_master.sv
// Turns decoded memory-write requests plus payload into AXI4 INCR write bursts,
// tracks outstanding B responses and reports response/protocol errors.
module axi4_rx_wr_master
   import axi4_pkg::*;
#(
   parameter int  ID_WIDTH        = AXI_ID_W,
   parameter int  ADDR_WIDTH      = AXI_ADDR_W,
   parameter int  DATA_WIDTH      = 256,
   parameter int  MAX_OUTSTANDING = 8,
   localparam int STRB_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]            req_len,
   input  logic [ID_WIDTH-1:0]   req_id,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic [STRB_WIDTH-1:0] din_strb,
   input  logic                  din_last,
   AXI4_A_IF.master              aw_if,
   AXI4_W_IF.master              w_if,
   AXI4_B_IF.master              b_if,
   output logic [7:0]            outstanding,
   output logic [15:0]           err_cnt,
   output logic                  proto_err,
   output logic                  idle
);

   localparam logic [2:0] ASIZE = axi_size(STRB_WIDTH);

   wr_state_e   state_q, state_d;
   wr_req_t     reqLatch_q, reqLatch_d;
   logic [7:0]  beatCnt_q, beatCnt_d;
   logic [15:0] errCnt_q;
   logic        protoErr_q;
   logic        running_q;
   logic        awFire, wFire, bFire, wlastInt;

   assign awFire   = aw_if.avalid & aw_if.aready;
   assign wFire    = w_if.wvalid & w_if.wready;
   assign bFire    = b_if.bvalid & b_if.bready;
   assign wlastInt = (beatCnt_q == reqLatch_q.len);

   // Next state and handshake outputs; W is a straight pass-through of the payload stream.
   always_comb begin
      state_d      = state_q;
      reqLatch_d   = reqLatch_q;
      beatCnt_d    = beatCnt_q;
      req_ready    = 1'b0;
      aw_if.avalid = 1'b0;
      w_if.wvalid  = 1'b0;
      din_ready    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = running_q && (outstanding < 8'(MAX_OUTSTANDING));
            if (req_valid && req_ready) begin
               reqLatch_d.addr = AXI_ADDR_W'(req_addr);
               reqLatch_d.len  = req_len;
               reqLatch_d.id   = AXI_ID_W'(req_id);
               beatCnt_d       = '0;
               state_d         = ST_AW;
            end
         end
         ST_AW: begin
            aw_if.avalid = 1'b1;
            if (aw_if.aready) state_d = ST_W;
         end
         ST_W: begin
            w_if.wvalid = din_valid;
            din_ready   = w_if.wready;
            if (din_valid && w_if.wready) begin
               beatCnt_d = beatCnt_q + 8'd1;
               if (wlastInt) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, latched request and beat counter.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q    <= ST_IDLE;
         reqLatch_q <= '0;
         beatCnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         reqLatch_q <= reqLatch_d;
         beatCnt_q  <= beatCnt_d;
      end
   end

   // Keeps req_ready and bready low until the first clock after reset release.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) running_q <= 1'b0;
      else           running_q <= 1'b1;
   end

   // Saturating count of error responses and sticky din_last/wlast disagreement.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         errCnt_q   <= '0;
         protoErr_q <= 1'b0;
      end else begin
         if (bFire && (b_if.bresp != AXI_RESP_OKAY) && (errCnt_q != 16'hFFFF)) begin
            errCnt_q <= errCnt_q + 16'd1;
         end
         if (wFire && (din_last != wlastInt)) begin
            protoErr_q <= 1'b1;
         end
      end
   end

   sat_updown_cnt #(.WIDTH(8)) u_outstanding (
      .clk     (aclk),
      .rst_n   (areset_n),
      .inc_i   (awFire),
      .dec_i   (bFire),
      .count_o (outstanding)
   );

   assign aw_if.aaddr   = ADDR_WIDTH'(reqLatch_q.addr);
   assign aw_if.aid     = ID_WIDTH'(reqLatch_q.id);
   assign aw_if.alen    = reqLatch_q.len;
   assign aw_if.asize   = ASIZE;
   assign aw_if.aburst  = AXI_BURST_INCR;
   assign aw_if.acache  = '0;
   assign aw_if.aprot   = '0;
   assign aw_if.aqos    = '0;
   assign aw_if.aregion = '0;

   assign w_if.wdata = din_data;
   assign w_if.wstrb = din_strb;
   assign w_if.wlast = wlastInt;

   assign b_if.bready = running_q;

   assign err_cnt   = errCnt_q;
   assign proto_err = protoErr_q;
   assign idle      = (state_q == ST_IDLE) && (outstanding == 8'd0);

   // A response with nothing outstanding means the fabric is misbehaving.
   assert property (@(posedge aclk) disable iff (!areset_n)
      bFire |-> (outstanding != 8'd0));

   // Requester promise: a burst never crosses a 4KB page.
   assert property (@(posedge aclk) disable iff (!areset_n)
      (req_valid && req_ready) |->
         (({20'd0, req_addr[11:0]} + (32'(req_len) + 32'd1) * 32'(STRB_WIDTH)) <= 32'd4096));

endmodule
